// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word, write-mask and memory-unit state types
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE,
        IND_RD,
        MEM_RD,
        MEM_WR
    } lc3b_memunit_state;

endpackage

// File: rtl/mem_lane_steer.sv
// rtl/mem_lane_steer.sv - byte-lane steering for LDB/STB accesses
// Pure combinational: byte enables, store replication and load lane extraction.
module mem_lane_steer (
    input  logic        addr_lsb,
    input  logic        is_byte,
    input  logic [15:0] wdata,
    input  logic [15:0] mem_rdata,
    output logic [1:0]  byte_enable,
    output logic [15:0] wdata_lane,
    output logic [15:0] rdata_lane
);

    always_comb begin
        byte_enable = 2'b11;
        wdata_lane  = wdata;
        rdata_lane  = mem_rdata;
        if (is_byte) begin
            byte_enable = addr_lsb ? 2'b10 : 2'b01;
            // the low byte is replicated so the memory sees it on whichever lane is enabled
            wdata_lane  = {wdata[7:0], wdata[7:0]};
            rdata_lane  = {8'h00, (addr_lsb ? mem_rdata[15:8] : mem_rdata[7:0])};
        end
    end

endmodule

// File: rtl/lc3b_mem_unit.sv
// rtl/lc3b_mem_unit.sv - LC-3b multi-cycle load/store sequencer
// One request at a time; optional pointer fetch for LDI/STI; wait-limit watchdog.
module lc3b_mem_unit
    import lc3b_types::*;
#(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic        req_indirect,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] rdata,
    output logic [15:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp
);

    localparam int CW = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(WAIT_LIMIT);

    lc3b_memunit_state state, next_state;

    logic          r_write, r_byte, r_indirect;
    lc3b_word      r_addr, r_wdata, ptr, eff_addr;
    logic [CW-1:0] wait_cnt;
    logic          accept, ptr_load, rd_load, finish, abort, timeout;
    lc3b_mem_wmask steer_be;
    lc3b_word      steer_wdata, steer_rdata;

    assign eff_addr = r_indirect ? ptr : r_addr;
    assign busy     = (state != IDLE);
    assign timeout  = (WAIT_LIMIT != 0) && (wait_cnt == LIMIT) && !mem_resp;

    mem_lane_steer u_steer (
        .addr_lsb    (eff_addr[0]),
        .is_byte     (r_byte),
        .wdata       (r_wdata),
        .mem_rdata   (mem_rdata),
        .byte_enable (steer_be),
        .wdata_lane  (steer_wdata),
        .rdata_lane  (steer_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // a response arriving in the limit cycle takes priority over the abort
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        ptr_load   = 1'b0;
        rd_load    = 1'b0;
        finish     = 1'b0;
        abort      = 1'b0;
        unique case (state)
            IDLE: if (req_valid) begin
                accept     = 1'b1;
                next_state = req_indirect ? IND_RD : (req_write ? MEM_WR : MEM_RD);
            end
            IND_RD: if (mem_resp) begin
                ptr_load   = 1'b1;
                next_state = r_write ? MEM_WR : MEM_RD;
            end else if (timeout) begin
                abort      = 1'b1;
                next_state = IDLE;
            end
            MEM_RD: if (mem_resp) begin
                rd_load    = 1'b1;
                finish     = 1'b1;
                next_state = IDLE;
            end else if (timeout) begin
                abort      = 1'b1;
                next_state = IDLE;
            end
            MEM_WR: if (mem_resp) begin
                finish     = 1'b1;
                next_state = IDLE;
            end else if (timeout) begin
                abort      = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_write    <= 1'b0;
            r_byte     <= 1'b0;
            r_indirect <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            ptr        <= '0;
            wait_cnt   <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
        end else begin
            done <= finish | abort;
            err  <= abort;
            if (accept) begin
                r_write    <= req_write;
                r_byte     <= req_byte;
                r_indirect <= req_indirect;
                r_addr     <= req_addr;
                r_wdata    <= req_wdata;
            end
            if (ptr_load) ptr <= mem_rdata;
            if (rd_load)  rdata <= steer_rdata;
            if (next_state != state)
                wait_cnt <= '0;
            else if (busy && (WAIT_LIMIT != 0) && (wait_cnt != LIMIT))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_byte_enable = '0;
        mem_wdata       = '0;
        unique case (state)
            IND_RD: begin
                mem_read        = 1'b1;
                mem_address     = {r_addr[15:1], 1'b0};
                mem_byte_enable = 2'b11;
            end
            MEM_RD: begin
                mem_read        = 1'b1;
                mem_address     = {eff_addr[15:1], 1'b0};
                mem_byte_enable = 2'b11;
            end
            MEM_WR: begin
                mem_write       = 1'b1;
                mem_address     = {eff_addr[15:1], 1'b0};
                mem_byte_enable = steer_be;
                mem_wdata       = steer_wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3b_mem_unit.sv
// tb/tb_lc3b_mem_unit.sv - self-checking bench for lc3b_mem_unit
module tb_lc3b_mem_unit;

    localparam int WL = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_write, req_byte, req_indirect;
    logic [15:0] req_addr, req_wdata;
    logic        busy, done, err;
    logic [15:0] rdata, mem_address, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_resp;
    logic [1:0]  mem_byte_enable;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] model_rdata;
    logic [15:0] mem [0:32767];

    lc3b_mem_unit #(.WAIT_LIMIT(WL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_byte(req_byte),
        .req_indirect(req_indirect), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        w, b, ind;
        logic [15:0] addr, wdata, ptr, data;
        int          pw, dw;
        logic [15:0] exp_addr;
        logic [1:0]  exp_be;
        logic [15:0] exp_wdata, exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one access state: memory answers after 'waits' cycles (never if waits > WL)
    task automatic phase(input logic rd, input logic wr, input logic [15:0] a, input logic [1:0] be,
                         input logic [15:0] wd, input int waits, input string tag, output logic aborted);
        aborted = 1'b1;
        for (int k = 0; k <= WL; k++) begin
            check({tag, " strobes"},
                  {busy, done, mem_read, mem_write, mem_address, mem_byte_enable, (wr ? mem_wdata : 16'h0)},
                  {1'b1, 1'b0, rd, wr, a, be, (wr ? wd : 16'h0)});
            req_valid    = 1'($urandom_range(0, 1));
            req_write    = 1'($urandom_range(0, 1));
            req_indirect = 1'($urandom_range(0, 1));
            req_addr     = 16'($urandom);
            req_wdata    = 16'($urandom);
            if (k == waits) begin
                mem_resp  = 1'b1;
                mem_rdata = mem[mem_address[15:1]];
                if (wr) begin
                    if (mem_byte_enable[0]) mem[mem_address[15:1]][7:0]  = mem_wdata[7:0];
                    if (mem_byte_enable[1]) mem[mem_address[15:1]][15:8] = mem_wdata[15:8];
                end
                aborted = 1'b0;
            end
            step();
            mem_resp  = 1'b0;
            mem_rdata = 16'($urandom);
            req_valid = 1'b0;
            if (!aborted) break;
        end
    endtask

    task automatic run_access(input logic w, input logic b, input logic ind,
                              input logic [15:0] addr, input logic [15:0] wdata, input int pw, input int dw,
                              input logic [15:0] exp_addr, input logic [1:0] exp_be,
                              input logic [15:0] exp_wdata, input logic [15:0] exp_rdata,
                              input logic exp_err, input string tag);
        logic ab;
        req_valid    = 1'b1;
        req_write    = w;
        req_byte     = b;
        req_indirect = ind;
        req_addr     = addr;
        req_wdata    = wdata;
        step();
        req_valid = 1'b0;
        ab = 1'b0;
        if (ind) phase(1'b1, 1'b0, {addr[15:1], 1'b0}, 2'b11, 16'h0, pw, {tag, " ptr"}, ab);
        if (!ab) phase(!w, w, exp_addr, exp_be, exp_wdata, dw, tag, ab);
        check({tag, " done"}, {busy, done, err, mem_read, mem_write}, {1'b0, 1'b1, exp_err, 1'b0, 1'b0});
        check({tag, " rdata"}, rdata, exp_rdata);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // w b ind addr wdata ptr data pw dw | addr be wdata rdata err
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 16'h3002, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 16'h3002, 2'b11, 16'h0000, 16'hBEEF, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 16'h4001, 16'h12A5, 16'h0000, 16'h0000, 0, 3, 16'h4000, 2'b10, 16'hA5A5, 16'hBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 16'h5001, 16'h0000, 16'h0000, 16'h80FF, 0, 1, 16'h5000, 2'b11, 16'h0000, 16'h0080, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'h5000, 16'h0000, 16'h0000, 16'h80FF, 0, 0, 16'h5000, 2'b11, 16'h0000, 16'h00FF, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 16'h6000, 16'h1234, 16'h7004, 16'h0000, 0, 0, 16'h7004, 2'b11, 16'h1234, 16'h00FF, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h1FFE, 16'h0000, 16'h0000, 16'hCAFE, 0, 4, 16'h1FFE, 2'b11, 16'h0000, 16'hCAFE, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 16'h2222, 16'h0000, 16'h0000, 16'h5555, 0, 9, 16'h2222, 2'b11, 16'h0000, 16'hCAFE, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 16'h8000, 16'h0000, 16'h9003, 16'h7E01, 2, 1, 16'h9002, 2'b11, 16'h0000, 16'h007E, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'hA001, 16'h0F0F, 16'h0000, 16'h0000, 0, 2, 16'hA000, 2'b11, 16'h0F0F, 16'h007E, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'h6100, 16'h4444, 16'h7100, 16'h0000, 9, 0, 16'h7100, 2'b11, 16'h4444, 16'h007E, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h4000, 16'h3377, 16'h0000, 16'h0000, 0, 0, 16'h4000, 2'b01, 16'h7777, 16'h007E, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 16'h6200, 16'h0000, 16'h6201, 16'h6201, 0, 0, 16'h6200, 2'b11, 16'h0000, 16'h6201, 1'b0};

        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_byte = 1'b0; req_indirect = 1'b0;
        req_addr = 16'h0; req_wdata = 16'h0; mem_rdata = 16'h0; mem_resp = 1'b0;
        model_rdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        check("reset outputs", {busy, done, err, mem_read, mem_write, mem_address, mem_byte_enable, mem_wdata}, 64'h0);
        check("reset rdata", rdata, 16'h0000);
        rst = 1'b0;
        step();
        check("idle after reset", {busy, done, err, mem_read, mem_write}, 64'h0);

        for (int i = 0; i < 12; i++) begin
            logic [15:0] ea;
            if (vecs[i].ind) mem[vecs[i].addr[15:1]] = vecs[i].ptr;
            ea = vecs[i].ind ? vecs[i].ptr : vecs[i].addr;
            if (!vecs[i].w) mem[ea[15:1]] = vecs[i].data;
            run_access(vecs[i].w, vecs[i].b, vecs[i].ind, vecs[i].addr, vecs[i].wdata, vecs[i].pw, vecs[i].dw,
                       vecs[i].exp_addr, vecs[i].exp_be, vecs[i].exp_wdata, vecs[i].exp_rdata, vecs[i].exp_err,
                       $sformatf("vec%0d", i));
            model_rdata = vecs[i].exp_rdata;
        end

        step();
        check("single done pulse", {busy, done, err, mem_read, mem_write}, 64'h0);
        mem_resp = 1'b1;
        mem_rdata = 16'hDEAD;
        step();
        mem_resp = 1'b0;
        check("resp in idle ignored", {busy, done, err, mem_read, mem_write}, 64'h0);
        check("resp in idle rdata", rdata, model_rdata);

        req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_indirect = 1'b0; req_addr = 16'h3002;
        step();
        req_valid = 1'b0;
        check("pre-reset read", {busy, mem_read}, 2'b11);
        step();
        rst = 1'b1;
        #1;
        check("async reset strobes", {busy, done, err, mem_read, mem_write}, 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();
        check("no done after reset", {busy, done, err, mem_read, mem_write}, 64'h0);
        check("rdata after reset", rdata, 16'h0000);
        model_rdata = 16'h0000;

        for (int i = 0; i < 150; i++) begin
            logic w, b, ind, perr, derr;
            logic [15:0] a, wd, ea, word, er;
            logic [1:0] be;
            int pw, dw;
            w   = 1'($urandom_range(0, 1));
            b   = 1'($urandom_range(0, 1));
            ind = 1'($urandom_range(0, 1));
            a   = 16'h2000 + 16'($urandom_range(0, 15));
            wd  = 16'($urandom);
            pw  = $urandom_range(0, 5);
            dw  = $urandom_range(0, 5);
            ea   = ind ? mem[a[15:1]] : a;
            word = mem[ea[15:1]];
            perr = ind && (pw > WL);
            derr = !perr && (dw > WL);
            be   = (w && b) ? (ea[0] ? 2'b10 : 2'b01) : 2'b11;
            if (!w && !perr && !derr)
                er = b ? (ea[0] ? {8'h00, word[15:8]} : {8'h00, word[7:0]}) : word;
            else
                er = model_rdata;
            run_access(w, b, ind, a, wd, pw, dw, {ea[15:1], 1'b0}, be,
                       (b ? {wd[7:0], wd[7:0]} : wd), er, perr | derr, $sformatf("rnd%0d", i));
            model_rdata = er;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
